// File: rtl/xbee_pkg.sv
// Shared types and constants for the XBee transmit path.
// Optional build macro: XBEE_TX_PARITY_EN (adds an even-parity bit after the data bits).
package xbee_pkg;

  // Serialiser states. PARITY is reachable only when XBEE_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Level driven on the serial line whenever no frame is in progress.
  localparam logic XBEE_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/xbee_sync_fifo.sv
// Synchronous FIFO with registered occupancy, first-word fall-through read
// and a single-cycle flush that discards every queued word.
module xbee_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_push_ok;
  logic w_pop_ok;

  // Flush wins over both push and pop; a push into a full FIFO is accepted
  // only when a pop frees an entry on the same edge.
  assign w_pop_ok  = pop  && !flush && !empty;
  assign w_push_ok = push && !flush && (!full || w_pop_ok);

  assign full  = (r_count == COUNT_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)
        r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; pointers define validity, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/xbee_tx_fifo_uart.sv
// Buffered XBee UART transmitter: FIFO in front of an LSB-first serialiser
// whose frame starts are gated by the XBee clear-to-send input Sent.
// Optional build macro: XBEE_TX_PARITY_EN (even-parity bit between data and stop).
module xbee_tx_fifo_uart
  import xbee_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ND,
  input  logic [DATA_W-1:0]        Din,
  input  logic                     Eviction,
  input  logic                     Sent,
  output logic                     DoutTx,
  output logic                     BusyFlag,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(DATA_W);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t          r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [DATA_W-1:0]  r_shift;
  logic [BIT_W-1:0]   r_bit_idx;
  logic               r_stop_idx;
  logic               r_dout;
  logic               r_busy;
  logic               r_overflow;

  tx_state_t          w_state_next;
  logic [TIMER_W-1:0] w_timer_next;
  logic [DATA_W-1:0]  w_shift_next;
  logic [BIT_W-1:0]   w_bit_next;
  logic               w_stop_next;
  logic               w_dout_next;
  logic               w_bit_end;
  logic               w_pop;

  logic [DATA_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic [$clog2(DEPTH):0] w_count;

`ifdef XBEE_TX_PARITY_EN
  logic r_parity;
  logic w_parity_next;
`endif

  xbee_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset),
    .push  (ND),
    .pop   (w_pop),
    .flush (Eviction),
    .din   (Din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign Full     = w_full;
  assign Empty    = w_empty;
  assign Count    = w_count;
  assign DoutTx   = r_dout;
  assign BusyFlag = r_busy;
  assign Overflow = r_overflow;

  assign w_bit_end = (r_timer == TIMER_MAX);

  // Next-state, bit timer, shift register and next line level for the serialiser.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_idx;
    w_stop_next  = r_stop_idx;
    w_pop        = 1'b0;
`ifdef XBEE_TX_PARITY_EN
    w_parity_next = r_parity;
`endif

    if (r_state != IDLE) begin
      w_timer_next = w_bit_end ? '0 : r_timer + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (!w_empty && Sent && !Eviction) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_state_next = START;
          w_timer_next = '0;
          w_bit_next   = '0;
          w_stop_next  = 1'b0;
`ifdef XBEE_TX_PARITY_EN
          w_parity_next = ^w_head;
`endif
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == BIT_LAST) begin
`ifdef XBEE_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_shift_next = {XBEE_IDLE_LEVEL, r_shift[DATA_W-1:1]};
            w_bit_next   = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef XBEE_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == STOP_LAST) w_state_next = IDLE;
          else                         w_stop_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
      end
    endcase

    // Line level is decoded from the upcoming state so DoutTx leaves a flop.
    case (w_state_next)
      START:   w_dout_next = 1'b0;
      DATA:    w_dout_next = w_shift_next[0];
`ifdef XBEE_TX_PARITY_EN
      PARITY:  w_dout_next = w_parity_next;
`endif
      default: w_dout_next = XBEE_IDLE_LEVEL;
    endcase
  end

  // Serialiser registers; reset aborts any frame and returns the line to idle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_dout     <= XBEE_IDLE_LEVEL;
      r_busy     <= 1'b0;
`ifdef XBEE_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_next;
      r_stop_idx <= w_stop_next;
      r_dout     <= w_dout_next;
      r_busy     <= (w_state_next != IDLE);
`ifdef XBEE_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  // Sticky overflow: a word offered while full with no pop to make room is lost.
  // Eviction clears it and also suppresses the push, so it never sets it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_overflow <= 1'b0;
    end else if (Eviction) begin
      r_overflow <= 1'b0;
    end else if (ND && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xbee_tx_fifo_uart.sv
// Directed bench for xbee_tx_fifo_uart: a cycle table for FIFO/status behaviour
// plus hand-written frame-level sequences. Honours XBEE_TX_PARITY_EN if defined.
module tb_xbee_tx_fifo_uart;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CPB    = 4;
  localparam int STOPB  = 1;
`ifdef XBEE_TX_PARITY_EN
  localparam int FRAME_BITS = 1 + DATA_W + 1 + STOPB;
`else
  localparam int FRAME_BITS = 1 + DATA_W + STOPB;
`endif
  localparam int FRAME_CYC = CPB * FRAME_BITS;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              ND = 1'b0;
  logic [DATA_W-1:0] Din = '0;
  logic              Eviction = 1'b0;
  logic              Sent = 1'b0;
  logic              DoutTx;
  logic              BusyFlag;
  logic              Full;
  logic              Empty;
  logic [2:0]        Count;
  logic              Overflow;

  int n_vec = 0;
  int n_err = 0;

  xbee_tx_fifo_uart #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (STOPB)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ND       (ND),
    .Din      (Din),
    .Eviction (Eviction),
    .Sent     (Sent),
    .DoutTx   (DoutTx),
    .BusyFlag (BusyFlag),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst_n;
    logic        nd;
    logic [7:0]  din;
    logic        evict;
    logic        exp_dout;
    logic        exp_busy;
    logic [2:0]  exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; ND = 1'b0; Eviction = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    ND = 1'b1; Din = d;
    tick();
    ND = 1'b0;
  endtask

  // Called when the start bit is expected to be on the line now; checks the
  // whole frame bit by bit and then the idle cycle that follows it.
  task automatic check_frame(input logic [7:0] d, input string tag);
    logic [FRAME_BITS-1:0] fb;
    fb[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) fb[1+i] = d[i];
`ifdef XBEE_TX_PARITY_EN
    fb[1+DATA_W] = ^d;
`endif
    fb[FRAME_BITS-1] = 1'b1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c > 0) tick();
      check($sformatf("%s dout c%0d", tag, c), DoutTx, fb[c/CPB]);
      check($sformatf("%s busy c%0d", tag, c), BusyFlag, 1);
    end
    tick();
    check({tag, " busy after"}, BusyFlag, 0);
    check({tag, " dout after"}, DoutTx, 1);
  endtask

  initial begin
    // rst_n nd din evict | dout busy count full empty ovf   (Sent held 0)
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

    #2;
    Sent = 1'b0;
    for (int v = 0; v < 12; v++) begin
      Reset = tbl[v].rst_n; ND = tbl[v].nd; Din = tbl[v].din; Eviction = tbl[v].evict;
      tick();
      check($sformatf("tbl%0d dout", v),  DoutTx,   tbl[v].exp_dout);
      check($sformatf("tbl%0d busy", v),  BusyFlag, tbl[v].exp_busy);
      check($sformatf("tbl%0d count", v), Count,    tbl[v].exp_count);
      check($sformatf("tbl%0d full", v),  Full,     tbl[v].exp_full);
      check($sformatf("tbl%0d empty", v), Empty,    tbl[v].exp_empty);
      check($sformatf("tbl%0d ovf", v),   Overflow, tbl[v].exp_ovf);
    end
    ND = 1'b0; Eviction = 1'b0; Reset = 1'b1;

    // Single frame: start bit two edges after ND is sampled.
    do_reset();
    Sent = 1'b1;
    push(8'hCE);
    check("single count after push", Count, 1);
    check("single dout before start", DoutTx, 1);
    check("single busy before start", BusyFlag, 0);
    tick();
    check("single count after pop", Count, 0);
    check("single empty after pop", Empty, 1);
    check_frame(8'hCE, "single");

    // Fill and overflow, then four back-to-back frames with one idle cycle between.
    do_reset();
    Sent = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    check("fill count", Count, 4);
    check("fill full", Full, 1);
    check("fill ovf", Overflow, 1);
    check("fill busy", BusyFlag, 0);
    Sent = 1'b1;
    tick();
    check_frame(8'hA1, "b2b0");
    tick();
    check_frame(8'hA2, "b2b1");
    tick();
    check_frame(8'hA3, "b2b2");
    tick();
    check_frame(8'hA4, "b2b3");
    check("b2b empty", Empty, 1);
    check("b2b count", Count, 0);
    check("b2b ovf sticky", Overflow, 1);
    tick();
    check("b2b no fifth frame", BusyFlag, 0);

    // Flow control: second push coincides with first pop; Sent dropped mid-frame.
    do_reset();
    Sent = 1'b1;
    push(8'h5B);
    check("flow count1", Count, 1);
    push(8'h96);
    check("flow push+pop count", Count, 1);
    Sent = 1'b0;
    check_frame(8'h5B, "flow1");
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("flow held busy %0d", i), BusyFlag, 0);
      check($sformatf("flow held count %0d", i), Count, 1);
    end
    Sent = 1'b1;
    tick();
    check("flow resume count", Count, 0);
    check_frame(8'h96, "flow2");

    // Eviction together with ND: queue flushed, ND word dropped, nothing sent.
    do_reset();
    Sent = 1'b0;
    push(8'h01); push(8'h02); push(8'h03);
    check("evict pre count", Count, 3);
    ND = 1'b1; Din = 8'h5A; Eviction = 1'b1;
    tick();
    ND = 1'b0; Eviction = 1'b0;
    check("evict count", Count, 0);
    check("evict empty", Empty, 1);
    check("evict ovf", Overflow, 0);
    Sent = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("evict idle busy %0d", i), BusyFlag, 0);
      check($sformatf("evict idle dout %0d", i), DoutTx, 1);
    end

    // Reset taken in the DATA state aborts the frame.
    do_reset();
    Sent = 1'b1;
    push(8'h3C);
    push(8'h81);
    check("rstmid start dout", DoutTx, 0);
    for (int i = 0; i < 6; i++) tick();
    check("rstmid in data busy", BusyFlag, 1);
    check("rstmid in data count", Count, 1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check("rstmid dout", DoutTx, 1);
    check("rstmid busy", BusyFlag, 0);
    check("rstmid count", Count, 0);
    check("rstmid empty", Empty, 1);
    tick();
    check("rstmid stays idle", BusyFlag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xbee_tx_fifo_uart.md
Name: xbee_tx_fifo_uart

Overview:
Parametrised successor to the single-byte XBee transmit path. It buffers words in a DEPTH-entry FIFO, serialises them LSB-first as UART frames on DoutTx, and gates each frame start on the XBee flow-control input Sent. It adds configurable width, depth, baud divisor and stop bits, plus occupancy/overflow status and FIFO eviction (flush). It sits between the host-side byte producer and the XBee DIN pin.

Parameters:
- DATA_W, 8: data bits per frame (5..9).
- DEPTH, 16: FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 434: Clk cycles per serial bit; 434 gives 115200 baud at 50 MHz. Minimum 2.
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset; 0 = reset.
- ND  in  1  new data; pushes Din on the cycle it is high.
- Din  in  DATA_W  word to enqueue.
- Eviction  in  1  flushes all queued, not-yet-started words; clears Overflow.
- Sent  in  1  XBee clear-to-send; 1 = a new frame may start.
- DoutTx  out  1  serial line; idles high.
- BusyFlag  out  1  high while a frame is on the line.
- Full  out  1  FIFO holds DEPTH words.
- Empty  out  1  FIFO holds 0 words.
- Count  out  $clog2(DEPTH)+1  FIFO occupancy.
- Overflow  out  1  sticky; set when ND arrives while the FIFO is full.

Behaviour:
- Reset values (Reset=0 at a clock edge): DoutTx=1, BusyFlag=0, Count=0, Empty=1, Full=0, Overflow=0. State is IDLE, the bit timer is 0 and the FIFO pointers are 0. Reset taken mid-frame aborts the frame and the line goes high the next cycle.
- Push: when ND=1 and the FIFO is not full, Din is written and Count increments. When ND=1 and the FIFO is full, the word is dropped and Overflow is set.
- Push and pop in the same cycle: Count is unchanged. A push while Full is accepted if a pop occurs in the same cycle.
- Eviction=1: the read pointer is set equal to the write pointer, Count=0 and Overflow=0. A frame already on the line completes.
- Eviction and ND in the same cycle: Eviction wins and the ND word is dropped. Overflow is not set.
- FSM states are IDLE, START, DATA, PARITY (only when PARITY_EN is defined) and STOP.
- IDLE: if Empty=0, Sent=1 and Eviction=0, pop the head word into the shift register and go to START. DoutTx=0 and BusyFlag=1 from the next cycle, so latency from pop to start bit is 1 cycle.
- Each state lasts exactly CLKS_PER_BIT cycles, timed by a bit timer that counts 0..CLKS_PER_BIT-1.
- START (DoutTx=0) goes to DATA.
- DATA shifts LSB-first for DATA_W bits, then goes to PARITY or STOP.
- STOP holds DoutTx=1 for STOP_BITS bit periods, then goes to IDLE with BusyFlag=0.
- Back-to-back frames: the earliest next start bit is 1 cycle after STOP ends, because that cycle is spent in IDLE.
- Sent is sampled only in IDLE. Deasserting Sent mid-frame does not stop the current frame.
- Frame length in cycles: CLKS_PER_BIT*(1+DATA_W+STOP_BITS), plus CLKS_PER_BIT when PARITY_EN is defined.
- Count, Full and Empty are registered and reflect the state after the current edge.

Optional Feature:
- Macro XBEE_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and transmits even parity (XOR of the data bits) for one bit period.
- Undefined: there is no PARITY state and the frame goes directly from DATA to STOP.

Decomposition:
- Package xbee_pkg holds the tx_state_t enum (IDLE, START, DATA, PARITY, STOP) and the constant XBEE_IDLE_LEVEL = 1'b1.
- One sub-module, xbee_sync_fifo, is natural: parameters DATA_W and DEPTH; ports push, pop, flush, din, dout, full, empty, count. The sub-module uses the same clock and reset.
- Serialiser FSM and bit timer stay in the top module.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1, DEPTH=4.
- Single frame: release Reset, one ND pulse with Din=0xCE, Sent=1. DoutTx shows 0, then 0,1,1,1,0,0,1,1, then 1, each bit 4 cycles (40 cycles total). BusyFlag is high for exactly 40 cycles. Start bit appears 2 cycles after ND.
- Fill and overflow: hold Sent=0 and push 5 words. Count=4, Full=1, Overflow=1. Raise Sent: 4 frames are sent back-to-back with 1 idle cycle between them, then Empty=1.
- Flow control: queue 2 words with Sent=1, then drop Sent during frame 1. Frame 1 completes. Frame 2 starts only after Sent returns to 1.
- Eviction: queue 3 words with Sent=0, then pulse Eviction together with ND. Count=0, Overflow=0, no frame is sent when Sent rises, and the ND word is dropped.
- Reset mid-frame: assert Reset=0 in the DATA state. Next cycle DoutTx=1, BusyFlag=0, Count=0.
- Parity build (XBEE_TX_PARITY_EN defined): Din=0xCE gives parity bit 1 before the stop bit, and the frame lasts 44 cycles.
